// File: rtl/iob_eth_mii_rx.sv
// MII receive path: preamble/SFD detection, nibble-to-byte assembly and an output FIFO of {last, data}.
// Optional FCS check is compiled in with `define IOB_ETH_MII_RX_CRC_CHECK_EN.
module iob_eth_mii_rx #(
    parameter int FIFO_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] RX_DATA,
    input  logic       RX_DV,
    output logic [7:0] m_data,
    output logic       m_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       crc_err
);

    localparam int DEPTH = 2 ** FIFO_W;

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t            state;
    logic              phase;
    logic [3:0]        nib_lo;
    logic [7:0]        stage_data;
    logic              stage_valid;
    logic [FIFO_W:0]   wr_ptr;
    logic [FIFO_W:0]   rd_ptr;
    logic [8:0]        mem [DEPTH];

    logic              byte_done;
    logic [7:0]        new_byte;
    logic              push_req;
    logic              push_last;
    logic              push_ok;
    logic              push_drop;
    logic              pop;
    logic              full;
    logic [8:0]        head;

    // The staged byte leaves when the next byte completes or when RX_DV drops.
    always_comb begin
        byte_done = (state == DATA) && RX_DV && phase;
        new_byte  = {RX_DATA, nib_lo};
        push_req  = (state == DATA) && stage_valid && (byte_done || !RX_DV);
        push_last = !RX_DV;
        full      = (wr_ptr[FIFO_W] != rd_ptr[FIFO_W]) &&
                    (wr_ptr[FIFO_W-1:0] == rd_ptr[FIFO_W-1:0]);
        m_valid   = (wr_ptr != rd_ptr);
        pop       = m_valid && m_ready;
        push_ok   = push_req && (!full || pop);
        push_drop = push_req && !push_ok;
        head      = mem[rd_ptr[FIFO_W-1:0]];
        m_data    = m_valid ? head[7:0] : 8'h00;
        m_last    = m_valid ? head[8] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 1'b0;
            nib_lo      <= 4'h0;
            stage_data  <= 8'h00;
            stage_valid <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            case (state)
                IDLE: begin
                    if (RX_DV) begin
                        if (RX_DATA == 4'h5) begin
                            state <= PRE;
                        end else begin
                            state     <= DROP;
                            frame_err <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (!RX_DV) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (RX_DATA == 4'hD) begin
                        state       <= DATA;
                        phase       <= 1'b0;
                        stage_valid <= 1'b0;
                    end else if (RX_DATA != 4'h5) begin
                        state     <= DROP;
                        frame_err <= 1'b1;
                    end
                end
                DATA: begin
                    if (!RX_DV) begin
                        // A dangling odd nibble or an empty frame is a framing error.
                        state       <= IDLE;
                        phase       <= 1'b0;
                        stage_valid <= 1'b0;
                        frame_err   <= !stage_valid || phase;
                        overflow    <= push_drop;
                    end else begin
                        phase <= ~phase;
                        if (!phase) begin
                            nib_lo <= RX_DATA;
                        end else begin
                            stage_data  <= new_byte;
                            stage_valid <= 1'b1;
                        end
                        if (push_drop) begin
                            state       <= DROP;
                            overflow    <= 1'b1;
                            stage_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    stage_valid <= 1'b0;
                    phase       <= 1'b0;
                    if (!RX_DV) state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers define validity and m_data/m_last are gated by m_valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[FIFO_W-1:0]] <= {push_last, stage_data};
    end

`ifdef IOB_ETH_MII_RX_CRC_CHECK_EN
    logic [31:0] crc;
    logic        sfd_hit;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign sfd_hit = (state == PRE) && RX_DV && (RX_DATA == 4'hD);

    // Register residue 0xDEBB20E3 is the bit-reversed form of the 0xC704DD7B magic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc     <= 32'hFFFFFFFF;
            crc_err <= 1'b0;
        end else begin
            crc_err <= push_ok && push_last && (crc != 32'hDEBB20E3);
            if (sfd_hit)        crc <= 32'hFFFFFFFF;
            else if (byte_done) crc <= crc_byte(crc, new_byte);
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_iob_eth_mii_rx.sv
// Directed bench for iob_eth_mii_rx: framing, FIFO, overflow, odd nibble, reset and (optionally) FCS check.
module tb_iob_eth_mii_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] RX_DATA = 4'h0;
    logic       RX_DV = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       frame_err;
    logic       overflow;
    logic       crc_err;

    int n_cmp = 0;
    int n_bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int crc_cnt = 0;

    always #5 clk = ~clk;

    iob_eth_mii_rx #(.FIFO_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .RX_DATA(RX_DATA), .RX_DV(RX_DV),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .overflow(overflow), .crc_err(crc_err)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
        if (crc_err)   crc_cnt++;
    end

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        RX_DV = 1'b1;
        RX_DATA = n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nib(b[3:0]);
        send_nib(b[7:4]);
    endtask

    task automatic send_preamble(input int n);
        repeat (n) send_nib(4'h5);
        send_nib(4'hD);
    endtask

    task automatic end_frame();
        @(negedge clk);
        RX_DV = 1'b0;
        RX_DATA = 4'h0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Returns {m_valid, m_data, m_last} at the head, then pops it.
    task automatic pop_entry(output logic [9:0] e);
        @(negedge clk);
        e = {m_valid, m_data, m_last};
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        RX_DV = 1'b1;
        RX_DATA = 4'h5;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({m_valid, m_data, m_last, frame_err, overflow, crc_err} !== 13'h0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: got v=%b d=%h l=%b fe=%b ov=%b crc=%b, want all 0",
                         i, m_valid, m_data, m_last, frame_err, overflow, crc_err);
            end
        end
        @(negedge clk);
        RX_DV = 1'b0;
        rst_n = 1'b1;
        settle();
    endtask

    task automatic test_basic_frame();
        logic [9:0] e;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_preamble(15);
        send_nib(4'h2); send_nib(4'h1); send_nib(4'h4);
        @(posedge clk); #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_no_early_push: got m_valid=%b, want 0", m_valid);
        end
        send_nib(4'h3);
        @(posedge clk); #1;
        n_cmp++;
        if ({m_valid, m_data, m_last} !== {1'b1, 8'h12, 1'b0}) begin
            n_bad++; $display("FAIL basic_push_latency: got v=%b d=%h l=%b, want v=1 d=12 l=0", m_valid, m_data, m_last);
        end
        end_frame();
        pop_entry(e);
        n_cmp++;
        if (e !== {1'b1, 8'h12, 1'b0}) begin
            n_bad++; $display("FAIL basic_pop0: got %h, want %h", e, {1'b1, 8'h12, 1'b0});
        end
        pop_entry(e);
        n_cmp++;
        if (e !== {1'b1, 8'h34, 1'b1}) begin
            n_bad++; $display("FAIL basic_pop1: got %h, want %h", e, {1'b1, 8'h34, 1'b1});
        end
        settle();
        n_cmp++;
        if ({m_valid, fe_cnt - fe0, ov_cnt - ov0} !== {1'b0, 32'd0, 32'd0}) begin
            n_bad++; $display("FAIL basic_clean: got m_valid=%b fe=%0d ov=%0d, want 0/0/0", m_valid, fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    task automatic test_bad_start();
        logic [9:0] e;
        int fe0;
        fe0 = fe_cnt;
        send_nib(4'h7);
        send_nib(4'h5); send_nib(4'hD); send_nib(4'h1); send_nib(4'h2);
        settle();
        n_cmp++;
        if ((fe_cnt - fe0) !== 1 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL bad_start: got fe_pulses=%0d m_valid=%b, want 1/0", fe_cnt - fe0, m_valid);
        end
        end_frame();
        settle();
        send_preamble(7);
        send_byte(8'hAB);
        end_frame();
        pop_entry(e);
        n_cmp++;
        if (e !== {1'b1, 8'hAB, 1'b1}) begin
            n_bad++; $display("FAIL bad_start_recover: got %h, want %h", e, {1'b1, 8'hAB, 1'b1});
        end
        n_cmp++;
        if ((fe_cnt - fe0) !== 1) begin
            n_bad++; $display("FAIL bad_start_fe_total: got %0d, want 1", fe_cnt - fe0);
        end
    endtask

    task automatic test_overflow();
        logic [9:0] e;
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_preamble(7);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        end_frame();
        settle();
        n_cmp++;
        if ((ov_cnt - ov0) !== 1 || (fe_cnt - fe0) !== 0) begin
            n_bad++; $display("FAIL ovf_pulse: got ov=%0d fe=%0d, want 1/0", ov_cnt - ov0, fe_cnt - fe0);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_entry(e);
            n_cmp++;
            if (e !== {1'b1, 8'(i), 1'b0}) begin
                n_bad++; $display("FAIL ovf_pop%0d: got %h, want %h", i, e, {1'b1, 8'(i), 1'b0});
            end
        end
        pop_entry(e);
        n_cmp++;
        if (e !== 10'h0) begin
            n_bad++; $display("FAIL ovf_empty: got %h, want 000", e);
        end
    endtask

    task automatic test_full_push_pop();
        logic [9:0] e;
        int ov0;
        ov0 = ov_cnt;
        send_preamble(7);
        for (int i = 1; i <= 5; i++) send_byte(8'hA0 + 8'(i));
        @(negedge clk);
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 8'hA1}) begin
            n_bad++; $display("FAIL full_head: got v=%b d=%h, want v=1 d=a1", m_valid, m_data);
        end
        RX_DV = 1'b0;
        RX_DATA = 4'h0;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            pop_entry(e);
            n_cmp++;
            if (e !== {1'b1, 8'hA0 + 8'(i), i == 5}) begin
                n_bad++; $display("FAIL full_pop%0d: got %h, want %h", i, e, {1'b1, 8'hA0 + 8'(i), i == 5});
            end
        end
        settle();
        n_cmp++;
        if ((ov_cnt - ov0) !== 0 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL full_no_ovf: got ov=%0d m_valid=%b, want 0/0", ov_cnt - ov0, m_valid);
        end
    endtask

    task automatic test_odd_nibble();
        logic [9:0] e;
        int fe0;
        fe0 = fe_cnt;
        send_preamble(7);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3);
        end_frame();
        pop_entry(e);
        n_cmp++;
        if (e !== {1'b1, 8'h21, 1'b1}) begin
            n_bad++; $display("FAIL odd_pop: got %h, want %h", e, {1'b1, 8'h21, 1'b1});
        end
        settle();
        n_cmp++;
        if ((fe_cnt - fe0) !== 1 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL odd_fe: got fe=%0d m_valid=%b, want 1/0", fe_cnt - fe0, m_valid);
        end
    endtask

    task automatic test_short_frames();
        int fe0;
        fe0 = fe_cnt;
        send_preamble(7);
        end_frame();
        settle();
        n_cmp++;
        if ((fe_cnt - fe0) !== 1 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL sfd_end: got fe=%0d m_valid=%b, want 1/0", fe_cnt - fe0, m_valid);
        end
        fe0 = fe_cnt;
        send_nib(4'h5); send_nib(4'h5);
        end_frame();
        settle();
        send_nib(4'h5); send_nib(4'h9); send_nib(4'hD); send_nib(4'h1); send_nib(4'h2);
        end_frame();
        settle();
        n_cmp++;
        if ((fe_cnt - fe0) !== 2 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL pre_abort: got fe=%0d m_valid=%b, want 2/0", fe_cnt - fe0, m_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] e;
        int fe0;
        send_preamble(7);
        send_byte(8'h11); send_byte(8'h22);
        send_nib(4'h3);
        @(posedge clk); #1;
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
            n_bad++; $display("FAIL rst_mid_before: got v=%b d=%h, want v=1 d=11", m_valid, m_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({m_valid, m_data, m_last, frame_err, overflow, crc_err} !== 13'h0) begin
            n_bad++; $display("FAIL rst_mid_async: got v=%b d=%h l=%b fe=%b ov=%b crc=%b, want all 0",
                              m_valid, m_data, m_last, frame_err, overflow, crc_err);
        end
        fe0 = fe_cnt;
        @(negedge clk);
        RX_DATA = 4'h4;
        @(negedge clk);
        rst_n = 1'b1;
        send_nib(4'h5); send_nib(4'hD);
        end_frame();
        settle();
        n_cmp++;
        if ((fe_cnt - fe0) !== 1 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_drop: got fe=%0d m_valid=%b, want 1/0", fe_cnt - fe0, m_valid);
        end
        send_preamble(15);
        send_byte(8'h5A);
        end_frame();
        pop_entry(e);
        n_cmp++;
        if (e !== {1'b1, 8'h5A, 1'b1}) begin
            n_bad++; $display("FAIL rst_mid_next: got %h, want %h", e, {1'b1, 8'h5A, 1'b1});
        end
    endtask

`ifdef IOB_ETH_MII_RX_CRC_CHECK_EN
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic test_crc();
        logic [7:0]  pay [60];
        logic [31:0] c;
        logic [31:0] fcs;
        int          crc0;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            pay[i] = 8'(i * 7 + 3);
            c = ref_crc(c, pay[i]);
        end
        fcs = ~c;
        m_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            crc0 = crc_cnt;
            send_preamble(15);
            for (int i = 0; i < 60; i++) send_byte(pay[i]);
            for (int j = 0; j < 4; j++) begin
                logic [7:0] fb;
                fb = fcs[8*j +: 8];
                if (pass == 1 && j == 0) fb = fb ^ 8'h01;
                send_byte(fb);
            end
            end_frame();
            @(posedge clk); #1;
            n_cmp++;
            if ({crc_err, m_valid, m_last} !== {pass == 1, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL crc_pass%0d: got crc=%b v=%b l=%b, want crc=%0d v=1 l=1",
                                  pass, crc_err, m_valid, m_last, pass);
            end
            settle();
            n_cmp++;
            if ((crc_cnt - crc0) !== pass) begin
                n_bad++; $display("FAIL crc_count%0d: got %0d, want %0d", pass, crc_cnt - crc0, pass);
            end
        end
        m_ready = 1'b0;
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_start();
        test_overflow();
        test_full_push_pop();
        test_odd_nibble();
        test_short_frames();
        test_reset_mid_frame();
`ifdef IOB_ETH_MII_RX_CRC_CHECK_EN
        test_crc();
`else
        n_cmp++;
        if (crc_cnt !== 0) begin
            n_bad++; $display("FAIL crc_tied_off: got %0d crc_err pulses, want 0", crc_cnt);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
